ps2_scan_decoder: RTL

Receives the serial PS/2 keyboard stream and decodes it into a held-key state for the keyboard path. It samples `ps2_clk`/`ps2_data`, checks each 11-bit frame, and handles the `F0` break prefix and the `E0` extended prefix. Its output is the current scan code, which drives the scan-code-to-ASCII lookup stage, plus a key-held flag and a press counter for the seven-segment display.

---
 rtl/ps2_scan_decoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 keyboard frame receiver and make/break parser.
// Optional mid-frame idle timeout is enabled by defining PS2_TIMEOUT_EN.
module ps2_scan_decoder #(
    parameter int PRESS_CNT_W    = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    output logic [7:0]             scan_code,
    output logic                   key_valid,
    output logic [PRESS_CNT_W-1:0] press_count,
    output logic                   new_press,
    output logic                   frame_err
);
    localparam logic [0:0] ST_MAKE  = 1'b0;
    localparam logic [0:0] ST_BREAK = 1'b1;

    logic       clk_s1, clk_s2, clk_prev;
    logic       data_s1, data_s2;
    logic       fall;
    logic [3:0] bit_idx;
    logic [9:0] frame_bits;
    logic [0:0] state;
    logic       frame_done, frame_ok, timeout;
    logic [7:0] rx_byte;

    // Synchronisers reset to 1 so an idle line does not look like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall       = clk_prev & ~clk_s2;
    assign frame_done = fall && (bit_idx == 4'd10);
    assign rx_byte    = frame_bits[8:1];
    // Start low, odd parity over data+parity, stop (the bit being sampled now) high.
    assign frame_ok   = ~frame_bits[0] & (^frame_bits[9:1]) & data_s2;

`ifdef PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout = !fall && (bit_idx != 4'd0) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (fall || timeout) begin
            to_cnt <= '0;
        end else if (bit_idx != 4'd0) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx    <= 4'd0;
            frame_bits <= '0;
        end else if (timeout) begin
            bit_idx <= 4'd0;
        end else if (fall) begin
            if (bit_idx == 4'd10) begin
                bit_idx <= 4'd0;
            end else begin
                frame_bits[bit_idx] <= data_s2;
                bit_idx             <= bit_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_MAKE;
            scan_code   <= 8'h00;
            key_valid   <= 1'b0;
            press_count <= '0;
            new_press   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            new_press <= 1'b0;
            frame_err <= timeout;
            if (frame_done) begin
                if (!frame_ok) begin
                    frame_err <= 1'b1;
                end else if (rx_byte != 8'hE0) begin
                    if (state == ST_MAKE) begin
                        if (rx_byte == 8'hF0) begin
                            state <= ST_BREAK;
                        end else if (!(key_valid && rx_byte == scan_code)) begin
                            scan_code   <= rx_byte;
                            key_valid   <= 1'b1;
                            press_count <= press_count + 1'b1;
                            new_press   <= 1'b1;
                        end
                    end else begin
                        if (rx_byte == scan_code) begin
                            key_valid <= 1'b0;
                        end
                        state <= ST_MAKE;
                    end
                end
            end
        end
    end
endmodule
